prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the instruction memory address width.
REQ-002 The module SHALL have parameter DATA_W, default 16, giving the instruction word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  global enable; while low, all state is frozen.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 base_addr  input  ADDR_W  first instruction memory address to write; sampled on an accepted start.
REQ-008 len  input  ADDR_W+1  number of words to load (0..256); sampled on an accepted start.
REQ-009 in_valid  input  1  upstream word valid.
REQ-010 in_data  input  DATA_W  upstream instruction word.
REQ-011 in_ready  output  1  loader can accept a word.
REQ-012 wr_en  output  1  instruction memory write strobe.
REQ-013 wr_addr  output  ADDR_W  instruction memory write address.
REQ-014 wr_data  output  DATA_W  instruction memory write data.
REQ-015 fetch_en  output  1  enable to the fetch unit; low holds the PC and opcode registers.
REQ-016 busy  output  1  high in LOAD and DONE.
REQ-017 done  output  1  one-cycle pulse when the load completes.
REQ-018 count  output  ADDR_W+1  number of words accepted in the current or last load.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD and DONE.
REQ-020 IDLE -> LOAD SHALL occur on an edge with en=1, start=1 and len!=0; base_addr and len are latched and count is cleared.
REQ-021 IDLE -> DONE SHALL occur on an edge with en=1, start=1 and len=0; no write is issued.
REQ-022 start SHALL be ignored in LOAD and DONE.
REQ-023 in_ready SHALL be combinational and equal (state==LOAD) & en.
REQ-024 A word SHALL be accepted on an edge where in_valid & in_ready is high.
REQ-025 Each accepted word SHALL produce registered outputs in the next cycle:
  - wr_en=1;
  - wr_addr=(base_addr+count) mod 2^ADDR_W;
  - wr_data=in_data;
  - count increments by 1.
REQ-026 wr_en SHALL be low in every cycle that does not follow an acceptance; wr_addr and wr_data SHALL hold their last values.
REQ-027 The address SHALL wrap modulo 2^ADDR_W (e.g. base 0xFE, len 4 writes 0xFE, 0xFF, 0x00, 0x01).
REQ-028 LOAD -> DONE SHALL occur on the edge that accepts word number len.
REQ-029 DONE -> IDLE SHALL occur on the next enabled edge.
REQ-030 done SHALL be 1 exactly while in DONE.
REQ-031 The last wr_en pulse SHALL coincide with the done cycle.
REQ-032 fetch_en SHALL equal (state==IDLE) & en.
REQ-033 Bubbles SHALL be allowed: in_valid low in LOAD stalls the load with no write and no count change.
REQ-034 While en=0, no state, count or output register SHALL change, in_ready SHALL be 0, and wr_en SHALL be forced to 0.
REQ-035 count SHALL retain its final value in IDLE until the next accepted start.

Reset
REQ-036 On an edge with rst=1, the state SHALL become IDLE and count, wr_en, wr_addr, wr_data and done SHALL become 0, regardless of en.
REQ-037 Reset mid-LOAD SHALL abort the load with no further writes; fetch_en SHALL return to en in the following cycle.
REQ-038 rst SHALL take priority over start and in_valid.

Configuration
REQ-039 With macro PROG_LOADER_CHECKSUM_EN defined:
  - the module SHALL add output checksum (DATA_W), the mod-2^DATA_W sum of all words accepted in the current load;
  - checksum SHALL be cleared on an accepted start and on rst;
  - checksum SHALL be updated in the same cycle as wr_en.
REQ-040 Without PROG_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-041 Basic load:
  - stimulus: rst, then start, base 0x10, len 3, words 0xA001, 0xA002, 0xA003 streamed back-to-back;
  - response: writes at 0x10, 0x11, 0x12 in consecutive cycles, done on the third write cycle, count=3, fetch_en low from the cycle after start until the cycle after done.
REQ-042 Wrap-around:
  - stimulus: base 0xFE, len 4;
  - response: wr_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-043 Zero length:
  - stimulus: start with len 0;
  - response: no wr_en, done high one cycle later, count=0.
REQ-044 Stalls:
  - stimulus: in_valid toggled 1,0,1, en dropped for 2 cycles mid-load, start re-asserted during LOAD;
  - response: exactly len writes, in_ready=0 while en=0, the second start ignored.
REQ-045 Reset mid-load:
  - stimulus: rst after 2 of 5 words;
  - response: state IDLE, count=0, no further wr_en.
REQ-046 Checksum (PROG_LOADER_CHECKSUM_EN defined):
  - stimulus: words 0xFFFF, 0x0002;
  - response: checksum=0x0001 at done.

Source files
------------

// File: rtl/prog_loader.sv
// Streams a block of instruction words into instruction memory, holding the fetch unit off while loading.
// Optional running checksum of loaded words: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fetch_en,
  output logic              busy,
  output logic              done,
`ifdef PROG_LOADER_CHECKSUM_EN
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum
`else
  output logic [ADDR_W:0]   count
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  count_inc;
  logic              start_ok;
  logic              accept;

  assign in_ready  = (state == LOAD) & en;
  assign fetch_en  = (state == IDLE) & en;
  assign count_inc = count + CNT_W'(1);
  assign start_ok  = (state == IDLE) & en & start;
  assign accept    = in_valid & in_ready;

  // Control FSM; busy/done are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (en) begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len;
            count  <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            wr_en   <= 1'b1;
            // Address arithmetic is ADDR_W wide so it wraps naturally.
            wr_addr <= base_q + count[ADDR_W-1:0];
            wr_data <= in_data;
            count   <= count_inc;
            if (count_inc == len_q) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end else begin
      wr_en <= 1'b0;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running sum of accepted words, updated in step with the write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = start_ok ^ accept;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as words are driven and
// popped as the loader strobes wr_en. Checksum checks appear with PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, en, start, in_valid;
  logic [7:0]  base_addr;
  logic [8:0]  len;
  logic [15:0] in_data;
  logic        in_ready, wr_en, fetch_en, busy, done;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [8:0]  count;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  n_writes = 0;
  int  w0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .base_addr(base_addr), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_en(fetch_en), .busy(busy), .done(done),
`ifdef PROG_LOADER_CHECKSUM_EN
    .count(count), .checksum(checksum)
`else
    .count(count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb_q.push_back(w);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    push_exp(a, d);
    tick();
    in_valid = 1'b0;
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_writes++;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; in_valid = 1'b0;
    base_addr = '0; len = '0; in_data = '0;
    tick();
    tick();
    check("rst_wr_en",   32'(wr_en),   32'd0);
    check("rst_count",   32'(count),   32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_fetch",   32'(fetch_en), 32'd1);
    check("rst_ready",   32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Basic three-word load.
    w0 = n_writes;
    do_start(8'h10, 9'd3);
    check("ld_busy",  32'(busy),     32'd1);
    check("ld_fetch", 32'(fetch_en), 32'd0);
    check("ld_ready", 32'(in_ready), 32'd1);
    send(8'h10, 16'hA001);
    check("b1_wr_en", 32'(wr_en), 32'd1);
    check("b1_done",  32'(done),  32'd0);
    send(8'h11, 16'hA002);
    check("b2_wr_en", 32'(wr_en), 32'd1);
    send(8'h12, 16'hA003);
    check("b3_wr_en", 32'(wr_en), 32'd1);
    check("b3_done",  32'(done),  32'd1);
    check("b3_count", 32'(count), 32'd3);
    check("b3_fetch", 32'(fetch_en), 32'd0);
    tick();
    check("b_after_done",  32'(done),     32'd0);
    check("b_after_busy",  32'(busy),     32'd0);
    check("b_after_fetch", 32'(fetch_en), 32'd1);
    check("b_after_wr_en", 32'(wr_en),    32'd0);
    check("b_count_hold",  32'(count),    32'd3);
    check("b_writes",      32'(n_writes - w0), 32'd3);
    check("b_sb_empty",    32'(sb_q.size()),   32'd0);

    // Address wrap past the top of memory.
    w0 = n_writes;
    do_start(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) send(8'(8'hFE + k), 16'($urandom));
    check("wrap_done",  32'(done),  32'd1);
    check("wrap_count", 32'(count), 32'd4);
    tick();
    check("wrap_writes",   32'(n_writes - w0), 32'd4);
    check("wrap_sb_empty", 32'(sb_q.size()),   32'd0);

    // Zero-length load goes straight to DONE.
    w0 = n_writes;
    do_start(8'h33, 9'd0);
    check("z_done",  32'(done),  32'd1);
    check("z_busy",  32'(busy),  32'd1);
    check("z_wr_en", 32'(wr_en), 32'd0);
    check("z_count", 32'(count), 32'd0);
    tick();
    check("z_done_end", 32'(done), 32'd0);
    check("z_writes",   32'(n_writes - w0), 32'd0);

    // Bubbles, enable drop and an ignored second start.
    w0 = n_writes;
    do_start(8'h40, 9'd3);
    in_valid = 1'b1; in_data = 16'h1111; push_exp(8'h40, 16'h1111);
    start = 1'b1; base_addr = 8'h80; len = 9'd7;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("s_count1", 32'(count), 32'd1);
    tick();
    check("s_bubble_wr_en", 32'(wr_en), 32'd0);
    check("s_bubble_count", 32'(count), 32'd1);
    en = 1'b0; in_valid = 1'b1; in_data = 16'h2222;
    #1;
    check("s_en0_ready", 32'(in_ready), 32'd0);
    check("s_en0_fetch", 32'(fetch_en), 32'd0);
    tick();
    check("s_en0_wr_en", 32'(wr_en), 32'd0);
    check("s_en0_count", 32'(count), 32'd1);
    check("s_en0_busy",  32'(busy),  32'd1);
    tick();
    check("s_en0_ready2", 32'(in_ready), 32'd0);
    check("s_en0_count2", 32'(count),    32'd1);
    en = 1'b1;
    push_exp(8'h41, 16'h2222);
    tick();
    in_valid = 1'b0;
    send(8'h42, 16'h3333);
    check("s_done",  32'(done),  32'd1);
    check("s_count", 32'(count), 32'd3);
    tick();
    check("s_done_end", 32'(done), 32'd0);
    check("s_writes",   32'(n_writes - w0), 32'd3);
    check("s_sb_empty", 32'(sb_q.size()),   32'd0);

    // Reset in the middle of a load.
    do_start(8'h20, 9'd5);
    send(8'h20, 16'hBEEF);
    send(8'h21, 16'hCAFE);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    tick();
    rst = 1'b0;
    check("r_busy",  32'(busy),     32'd0);
    check("r_done",  32'(done),     32'd0);
    check("r_count", 32'(count),    32'd0);
    check("r_wr_en", 32'(wr_en),    32'd0);
    check("r_fetch", 32'(fetch_en), 32'd1);
    check("r_ready", 32'(in_ready), 32'd0);
    w0 = n_writes;
    tick();
    tick();
    in_valid = 1'b0;
    check("r_writes",   32'(n_writes - w0), 32'd0);
    check("r_sb_empty", 32'(sb_q.size()),   32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum wraps modulo 2^16.
    do_start(8'h50, 9'd2);
    send(8'h50, 16'hFFFF);
    send(8'h51, 16'h0002);
    check("cs_done",     32'(done),     32'd1);
    check("cs_checksum", 32'(checksum), 32'h0001);
    tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
